// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port numbering, output-mux select
// encoding and small port-index helpers.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    typedef logic [2:0] port_idx_t;

    localparam port_idx_t PORT_N = 3'd0;
    localparam port_idx_t PORT_S = 3'd1;
    localparam port_idx_t PORT_E = 3'd2;
    localparam port_idx_t PORT_W = 3'd3;
    localparam port_idx_t PORT_L = 3'd4;

    // Output mux select: values 0..4 pick the matching input port,
    // SEL_IDLE tri-states the mux output.
    localparam logic [2:0] SEL_IDLE = 3'b111;

    // Next port in round-robin order, wrapping L back to N.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == PORT_L) ? PORT_N : port_idx_t'(p + 3'd1);
    endfunction

    // One-hot vector for a port index.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
        logic [NUM_PORTS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (p == port_idx_t'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational 5-way round-robin picker: first requester at or after the
// pointer, wrapping L -> N. Shared with the input-side VC allocator.
module rr_pick5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            pointer,
    output logic                 any,
    output port_idx_t            winner
);

    port_idx_t w_idx;

    // Walk the five ports starting at the pointer; keep the first hit.
    always_comb begin
        any    = 1'b0;
        winner = PORT_N;
        w_idx  = pointer;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!any && req[w_idx]) begin
                any    = 1'b1;
                winner = w_idx;
            end
            w_idx = next_port(w_idx);
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output-port arbiter: round-robin choice among N/S/E/W/L with the
// winner locked until its tail flit transfers or the flit watchdog trips.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int MAX_PKT_FLITS = 16,
    parameter int CNT_W         = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 out_ready,
    output logic [2:0]           mux_sel,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 out_valid,
    output logic [NUM_PORTS-1:0] ack,
    output logic                 wdog_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_PKT_FLITS - 1);

    logic [0:0]           r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [2:0]           r_sel;
    port_idx_t            r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_wdog;

    logic                 w_any;
    port_idx_t            w_winner;
    logic                 w_vld;
    logic                 w_tail_g;
    logic                 w_fire;
    logic                 w_limit;

    rr_pick5 u_pick (
        .req     (req),
        .pointer (r_ptr),
        .any     (w_any),
        .winner  (w_winner)
    );

    // Granted-input view; r_grant is zero when idle, so these are too.
    always_comb begin
        w_vld    = |(req & r_grant);
        w_tail_g = |(tail & r_grant);
        w_fire   = w_vld & out_ready;
        w_limit  = (r_cnt == CNT_LIMIT);
    end

    // Arbitration state, lock, flit counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= SEL_IDLE;
            r_ptr   <= PORT_N;
            r_cnt   <= '0;
            r_wdog  <= 1'b0;
        end else begin
            r_wdog <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_LOCKED;
                        r_grant <= port_onehot(w_winner);
                        r_sel   <= w_winner;
                        r_cnt   <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_fire) begin
                        if (w_tail_g || w_limit) begin
                            // Tail wins over the watchdog when both hit together.
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_sel   <= SEL_IDLE;
                            r_ptr   <= next_port(port_idx_t'(r_sel));
                            r_cnt   <= '0;
                            r_wdog  <= !w_tail_g;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_sel   <= SEL_IDLE;
                end
            endcase
        end
    end

    // Output drive.
    always_comb begin
        grant     = r_grant;
        mux_sel   = r_sel;
        out_valid = w_vld;
        ack       = r_grant & {NUM_PORTS{w_fire}};
        wdog_err  = r_wdog;
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Bench for noc_output_arbiter: per-cycle vector tables with hand-derived
// expected outputs, routed through an expectation queue.
module tb_noc_output_arbiter;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] tail;
    logic       out_ready;
    logic [2:0] mux_sel;
    logic [4:0] grant;
    logic       out_valid;
    logic [4:0] ack;
    logic       wdog_err;

    noc_output_arbiter #(.MAX_PKT_FLITS(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .tail      (tail),
        .out_ready (out_ready),
        .mux_sel   (mux_sel),
        .grant     (grant),
        .out_valid (out_valid),
        .ack       (ack),
        .wdog_err  (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] req;
        logic [4:0] tail;
        logic       rdy;
        logic [4:0] grant;
        logic [2:0] sel;
        logic       vld;
        logic [4:0] ack;
        logic       wdog;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t V(input logic [4:0] r, input logic [4:0] t, input logic rd,
                               input logic [4:0] g, input logic [2:0] s, input logic v,
                               input logic [4:0] a, input logic w);
        vec_t x;
        x.req = r; x.tail = t; x.rdy = rd;
        x.grant = g; x.sel = s; x.vld = v; x.ack = a; x.wdog = w;
        return x;
    endfunction

    function automatic logic [14:0] actual_bits();
        return {grant, mux_sel, out_valid, ack, wdog_err};
    endfunction

    task automatic compare(input string name, input logic [14:0] expv);
        logic [14:0] act;
        act = actual_bits();
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got grant=%b sel=%b vld=%b ack=%b wdog=%b, want grant=%b sel=%b vld=%b ack=%b wdog=%b",
                     name, $time, act[14:10], act[9:7], act[6], act[5:1], act[0],
                     expv[14:10], expv[9:7], expv[6], expv[5:1], expv[0]);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check at negedge.
    task automatic apply(input vec_t v, input string name);
        vec_t e;
        req = v.req; tail = v.tail; out_ready = v.rdy;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        compare(name, {e.grant, e.sel, e.vld, e.ack, e.wdog});
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("%s[%0d]", name, i));
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; tail = '0; out_ready = 1'b0;
        #1;
        compare("reset_values", {5'b0, 3'b111, 1'b0, 5'b0, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req = '0; tail = '0; out_ready = 1'b0;
        #2;
        do_reset();

        // Single-flit packet on E, then pointer=3 makes W beat N.
        tbl.push_back(V(5'b00100, 5'b00100, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b00100, 5'b00100, 1, 5'b00100, 3'b010, 1, 5'b00100, 0));
        tbl.push_back(V(5'b00000, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b01001, 5'b11111, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b01001, 5'b11111, 1, 5'b01000, 3'b011, 1, 5'b01000, 0));
        tbl.push_back(V(5'b00000, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        run_table("t1_single");

        do_reset();
        // All requesting, every flit a tail: N,S,E,W,L,N with bubbles.
        for (int i = 0; i < 6; i++) begin
            logic [4:0] oh;
            oh = 5'b00001 << (i % 5);
            tbl.push_back(V(5'b11111, 5'b11111, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
            tbl.push_back(V(5'b11111, 5'b11111, 1, oh, 3'(i % 5), 1, oh, 0));
        end
        tbl.push_back(V(5'b00000, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        run_table("t2_rr");

        // Pointer=1: W alone, then E also requests; ready toggles.
        tbl.push_back(V(5'b01000, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b01100, 5'b00000, 1, 5'b01000, 3'b011, 1, 5'b01000, 0));
        tbl.push_back(V(5'b01100, 5'b00000, 0, 5'b01000, 3'b011, 1, 5'b00000, 0));
        tbl.push_back(V(5'b01100, 5'b00000, 1, 5'b01000, 3'b011, 1, 5'b01000, 0));
        tbl.push_back(V(5'b01100, 5'b00000, 0, 5'b01000, 3'b011, 1, 5'b00000, 0));
        tbl.push_back(V(5'b01100, 5'b00000, 1, 5'b01000, 3'b011, 1, 5'b01000, 0));
        tbl.push_back(V(5'b01100, 5'b01000, 0, 5'b01000, 3'b011, 1, 5'b00000, 0));
        tbl.push_back(V(5'b01100, 5'b01000, 1, 5'b01000, 3'b011, 1, 5'b01000, 0));
        run_table("t3_toggle");

        // Pointer=4: E granted, drops req 3 cycles while N requests.
        tbl.push_back(V(5'b00100, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b00100, 5'b00000, 1, 5'b00100, 3'b010, 1, 5'b00100, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(V(5'b00001, 5'b00000, 1, 5'b00100, 3'b010, 0, 5'b00000, 0));
        tbl.push_back(V(5'b00100, 5'b00000, 1, 5'b00100, 3'b010, 1, 5'b00100, 0));
        tbl.push_back(V(5'b00100, 5'b00100, 1, 5'b00100, 3'b010, 1, 5'b00100, 0));
        run_table("t4_stall");

        // Pointer=3: W never sends tail, watchdog releases after 16 acks.
        tbl.push_back(V(5'b01000, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        for (int i = 0; i < 16; i++)
            tbl.push_back(V(5'b11111, 5'b00000, 1, 5'b01000, 3'b011, 1, 5'b01000, 0));
        tbl.push_back(V(5'b11111, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 1));
        tbl.push_back(V(5'b11111, 5'b10000, 1, 5'b10000, 3'b100, 1, 5'b10000, 0));
        // Pointer=0: N sends 16 flits with tail on the 16th plus one stall.
        tbl.push_back(V(5'b00001, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        for (int i = 0; i < 16; i++) begin
            if (i == 8)
                tbl.push_back(V(5'b00001, 5'b00000, 0, 5'b00001, 3'b000, 1, 5'b00000, 0));
            tbl.push_back(V(5'b00001, (i == 15) ? 5'b00001 : 5'b00000, 1,
                            5'b00001, 3'b000, 1, 5'b00001, 0));
        end
        tbl.push_back(V(5'b00000, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        run_table("t5_wdog");

        // Lock on L (pointer=1 here: only L requests), then async reset mid-packet.
        tbl.push_back(V(5'b10000, 5'b00000, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b10000, 5'b00000, 1, 5'b10000, 3'b100, 1, 5'b10000, 0));
        run_table("t6_lock");
        req = 5'b10000; tail = 5'b00000; out_ready = 1'b1;
        #2;
        compare("t6_pre_reset", {5'b10000, 3'b100, 1'b1, 5'b10000, 1'b0});
        rst_n = 1'b0;
        #1;
        compare("t6_async_reset", {5'b00000, 3'b111, 1'b0, 5'b00000, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tbl.push_back(V(5'b10001, 5'b10001, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b10001, 5'b10001, 1, 5'b00001, 3'b000, 1, 5'b00001, 0));
        tbl.push_back(V(5'b10001, 5'b10001, 1, 5'b00000, 3'b111, 0, 5'b00000, 0));
        tbl.push_back(V(5'b00000, 5'b00000, 1, 5'b10000, 3'b100, 0, 5'b00000, 0));
        run_table("t6_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
